ilog: RTL
=========

ILOG -- requirements
Module: ilog

Interface
REQ-001 SHALL have parameter X_W, default 14, width of operand x and result pow_out.
REQ-002 SHALL have parameter B_W, default 7, width of base operand.
REQ-003 SHALL have parameter E_W, default 4, width of exponent result.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 x  input  X_W  unsigned value whose log is taken; sampled with start.
REQ-008 base  input  B_W  unsigned log base; sampled with start.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  single-cycle pulse; results valid.
REQ-011 exp_out  output  E_W  floor(log_base(x)).
REQ-012 pow_out  output  X_W  base^exp_out, the largest power of base not exceeding x.
REQ-013 exact  output  1  high when pow_out == x.
REQ-014 err  output  1  high when operands are invalid (base < 2 or x == 0).

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE with start=1 SHALL latch x and base, set acc=1 and e=0, and go to RUN; if operands are invalid, it SHALL go to DONE instead.
REQ-017 RUN SHALL form p = acc*base at X_W+B_W bits, so no truncation occurs.
REQ-018 RUN with p <= latched x SHALL set acc<=p and e<=e+1, and stay in RUN.
REQ-019 RUN with p > latched x SHALL go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 On entering DONE, the block SHALL load exp_out=e, pow_out=acc and exact=(acc==x).
REQ-022 On an invalid start, the block SHALL load err=1, exp_out=0, pow_out=0 and exact=0; on a valid start, err=0.
REQ-023 Timing: start sampled at cycle 0 SHALL give done at cycle e+2 for valid operands and at cycle 1 for invalid ones.
REQ-024 exp_out, pow_out, exact and err SHALL hold their values until the next DONE.
REQ-025 start SHALL be ignored while busy; the latched operands SHALL NOT change mid-operation.
REQ-026 x < base (valid) SHALL yield exp_out=0, pow_out=1, exact=(x==1).
REQ-027 start asserted in the same cycle DONE is present SHALL be ignored; a new request is accepted only in IDLE.

Reset
REQ-028 rst SHALL force state IDLE and set busy, done, exp_out, pow_out, exact, err, acc and e to 0, overriding any other event in that cycle.
REQ-029 rst asserted mid-operation SHALL abort the operation with no done pulse.

Structure
REQ-030 A shared package SHALL hold the default widths X_W, B_W, E_W and the FSM state enum (IDLE, RUN, DONE).
REQ-031 Implementation SHALL be a single module with no sub-module; the multiply-compare is inline combinational logic in RUN.

Verification
REQ-032 Bench SHALL check x=1000, base=10, start@0 -> done@5, exp_out=3, pow_out=1000, exact=1, err=0.
REQ-033 Bench SHALL check x=127, base=2 -> done@8, exp_out=6, pow_out=64, exact=0.
REQ-034 Bench SHALL check x=16383, base=127 -> exp_out=2, pow_out=16129, exact=0 (product width, no overflow); and x=5, base=7 -> done@2, exp_out=0, pow_out=1.
REQ-035 Bench SHALL check base=1, x=50 -> done@1, err=1, exp_out=0, pow_out=0; and x=0, base=3 -> err=1.
REQ-036 Bench SHALL check start pulsed again at cycle 2 with x=9, base=3 during an x=1000, base=10 run -> ignored, result still exp_out=3.
REQ-037 Bench SHALL check rst at cycle 3 of the x=1000, base=10 run -> no done, all outputs 0, busy=0 next cycle; a following start completes normally.

Source files
------------

// File: rtl/ilog_pkg.sv
// Shared definitions for the integer-logarithm block: default operand widths
// and the FSM state encoding.
package ilog_pkg;

  localparam int ILOG_X_W = 14;
  localparam int ILOG_B_W = 7;
  localparam int ILOG_E_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ilog_state_e;

endpackage

// File: rtl/ilog_if.sv
// Request/result bundle for ilog. The master drives start/x/base; the block
// returns busy, a one-cycle done pulse, the held results and its FSM state.
interface ilog_if
  import ilog_pkg::*;
#(
   parameter int X_W = ILOG_X_W,
   parameter int B_W = ILOG_B_W,
   parameter int E_W = ILOG_E_W
) ();

   // start is only looked at while the block is idle; there is no ready, so a
   // request raised while busy (or during the done cycle) is simply dropped.
   logic             start;
   logic [X_W-1:0]   x;
   logic [B_W-1:0]   base;
   logic             busy;
   logic             done;
   logic [E_W-1:0]   exp_out;
   logic [X_W-1:0]   pow_out;
   logic             exact;
   logic             err;
   ilog_state_e      state_dbg;

   modport master (
      output start, x, base,
      input  busy, done, exp_out, pow_out, exact, err, state_dbg
   );

   modport slave (
      input  start, x, base,
      output busy, done, exp_out, pow_out, exact, err, state_dbg
   );

endinterface

// File: rtl/ilog.sv
// Iterative floor(log_base(x)): multiplies an accumulator by base once per
// cycle until the next power would exceed x, then publishes exponent and power.
module ilog
  import ilog_pkg::*;
#(
   parameter int X_W = ILOG_X_W,
   parameter int B_W = ILOG_B_W,
   parameter int E_W = ILOG_E_W
) (
   input  logic  clk,
   input  logic  rst,
   ilog_if.slave bus
);

   localparam int P_W = X_W + B_W;

   ilog_state_e    state_q, state_d;
   logic [X_W-1:0] x_q, x_d;
   logic [B_W-1:0] base_q, base_d;
   logic [X_W-1:0] acc_q, acc_d;
   logic [E_W-1:0] e_q, e_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [E_W-1:0] exp_out_q, exp_out_d;
   logic [X_W-1:0] pow_out_q, pow_out_d;
   logic           exact_q, exact_d;
   logic           err_q, err_d;

   // Full-width product: acc*base can never wrap before it is compared to x.
   logic [P_W-1:0] p;
   logic           p_fits;
   logic           start_bad;

   assign p         = P_W'(acc_q) * P_W'(base_q);
   assign p_fits    = (p <= P_W'(x_q));
   assign start_bad = (bus.base < B_W'(2)) || (bus.x == '0);

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      base_d    = base_q;
      acc_d     = acc_q;
      e_d       = e_q;
      done_d    = 1'b0;
      exp_out_d = exp_out_q;
      pow_out_d = pow_out_q;
      exact_d   = exact_q;
      err_d     = err_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               x_d    = bus.x;
               base_d = bus.base;
               acc_d  = X_W'(1);
               e_d    = '0;
               if (start_bad) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  err_d     = 1'b1;
                  exp_out_d = '0;
                  pow_out_d = '0;
                  exact_d   = 1'b0;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (p_fits) begin
               acc_d = p[X_W-1:0];
               e_d   = e_q + E_W'(1);
            end else begin
               state_d   = DONE;
               done_d    = 1'b1;
               err_d     = 1'b0;
               exp_out_d = e_q;
               pow_out_d = acc_q;
               exact_d   = (acc_q == x_q);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         x_q       <= '0;
         base_q    <= '0;
         acc_q     <= '0;
         e_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         exp_out_q <= '0;
         pow_out_q <= '0;
         exact_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         base_q    <= base_d;
         acc_q     <= acc_d;
         e_q       <= e_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         exp_out_q <= exp_out_d;
         pow_out_q <= pow_out_d;
         exact_q   <= exact_d;
         err_q     <= err_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.exp_out   = exp_out_q;
   assign bus.pow_out   = pow_out_q;
   assign bus.exact     = exact_q;
   assign bus.err       = err_q;
   assign bus.state_dbg = state_q;

endmodule
